// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        DONE
    } arb_state_e;

    localparam int unsigned P_IF   = 0;
    localparam int unsigned P_LS   = 1;
    localparam int unsigned STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester + SRAM bus bundle for mem_port_arbiter; slave is the arbiter's view.
// Statistics signals exist only when MEM_PORT_ARB_STATS_EN is defined.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ready0, ready1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              CEN, WEN, OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D, Q;
`ifdef MEM_PORT_ARB_STATS_EN
    logic [STAT_W-1:0] gnt_cnt0, gnt_cnt1, conflict_cnt;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Q,
        input  ready0, ready1, rdata0, rdata1, CEN, WEN, OEN, A, D,
        input  gnt_cnt0, gnt_cnt1, conflict_cnt
    );
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Q,
        output ready0, ready1, rdata0, rdata1, CEN, WEN, OEN, A, D,
        output gnt_cnt0, gnt_cnt1, conflict_cnt
    );
`else
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Q,
        input  ready0, ready1, rdata0, rdata1, CEN, WEN, OEN, A, D
    );
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Q,
        output ready0, ready1, rdata0, rdata1, CEN, WEN, OEN, A, D
    );
`endif
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant and pointer update (points away from the winner).
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = '0;
        endcase
        ptr_o = ptr_i;
        if (adv_i && (gnt_o != 2'b00)) begin
            ptr_o = gnt_o[0];
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch (port 0) and load/store (port 1).
// Define MEM_PORT_ARB_STATS_EN to add saturating grant/conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        req, gnt_vec;
    logic              grant;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [1:0]        ready_q, ready_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    assign req = {bus.req1, bus.req0};

    rr_arb2 u_rr_arb2 (
        .req_i (req),
        .ptr_i (ptr_q),
        .adv_i (state_q == IDLE),
        .gnt_o (gnt_vec),
        .ptr_o (ptr_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: if (req != 2'b00) state_d = CMD;
            CMD: begin
                if (MEM_LAT > 1) begin
                    state_d = WAIT;
                    lat_d   = LAT_LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (lat_q == '0) state_d = DONE;
                else             lat_d   = lat_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM drive and completion signals are computed from state_d so every output is a flop.
    always_comb begin
        grant = (state_q == IDLE) && (gnt_vec != 2'b00);
        gnt_d = gnt_q;
        we_d  = we_q;
        a_d   = a_q;
        d_d   = d_q;
        if (grant) begin
            gnt_d = gnt_vec[P_LS];
            we_d  = gnt_vec[P_LS] ? bus.we1    : bus.we0;
            a_d   = gnt_vec[P_LS] ? bus.addr1  : bus.addr0;
            d_d   = gnt_vec[P_LS] ? bus.wdata1 : bus.wdata0;
        end
        cen_d    = (state_d != CMD);
        wen_d    = (state_d == CMD) ? ~we_d : 1'b1;
        ready_d  = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_d == DONE) begin
            ready_d[gnt_q] = 1'b1;
            if (!we_q) begin
                if (gnt_q) rdata1_d = bus.Q;
                else       rdata0_d = bus.Q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            cen_q    <= 1'b1;
            wen_q    <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
            ready_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            a_q      <= a_d;
            d_q      <= d_d;
            ready_q  <= ready_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.CEN    = cen_q;
    assign bus.WEN    = wen_q;
    assign bus.A      = a_q;
    assign bus.D      = d_q;
    assign bus.OEN    = 1'b0;
    assign bus.ready0 = ready_q[P_IF];
    assign bus.ready1 = ready_q[P_LS];
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

`ifdef MEM_PORT_ARB_STATS_EN
    logic [STAT_W-1:0] gnt_cnt0_q, gnt_cnt1_q, conflict_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (grant && gnt_vec[P_IF]) gnt_cnt0_q <= sat_inc(gnt_cnt0_q);
            if (grant && gnt_vec[P_LS]) gnt_cnt1_q <= sat_inc(gnt_cnt1_q);
            if ((state_q == IDLE) && (req == 2'b11)) conflict_cnt_q <= sat_inc(conflict_cnt_q);
        end
    end

    assign bus.gnt_cnt0     = gnt_cnt0_q;
    assign bus.gnt_cnt1     = gnt_cnt1_q;
    assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam logic [31:0] BAD = 32'hBAD0_0BAD;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wen;
        logic [6:0]  a;
        logic [31:0] d;
        int          cyc;
    } cmd_t;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    rsp_t rq1[$], rq3[$];
    cmd_t cq1[$], cq3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus3 ();

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    // SRAM models: Q must be stable at the edge MEM_LAT edges after the CEN-low cycle begins.
    logic [31:0] mem1 [128];
    logic [31:0] mem3 [128];
    logic        mem_init = 1'b0;
    logic [31:0] p1, p2;

    assign bus1.Q = (!bus1.CEN) ? mem1[bus1.A] : BAD;
    assign bus3.Q = p2;

    always @(posedge clk) begin
        if (!mem_init) begin
            mem1[7'h05] <= 32'hDEAD_BEEF;
            mem3[7'h22] <= 32'hCAFE_F00D;
            mem3[7'h23] <= 32'h1111_2222;
            mem3[7'h24] <= 32'h5555_AAAA;
            mem_init    <= 1'b1;
        end else begin
            if (!bus1.CEN && !bus1.WEN) mem1[bus1.A] <= bus1.D;
            if (!bus3.CEN && !bus3.WEN) mem3[bus3.A] <= bus3.D;
        end
        p1 <= (!bus3.CEN) ? mem3[bus3.A] : BAD;
        p2 <= p1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event at cycle %0d expected none", name, cyc);
    endtask

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (rst1 === 1'b0) begin
            if (!bus1.CEN) begin
                if (cq1.size() == 0) unexpected("cmd1_extra");
                else begin
                    c = cq1.pop_front();
                    chk("cmd1_cyc", 64'(cyc), 64'(c.cyc));
                    chk("cmd1_WEN", 64'(bus1.WEN), 64'(c.wen));
                    chk("cmd1_A", 64'(bus1.A), 64'(c.a));
                    chk("cmd1_D", 64'(bus1.D), 64'(c.d));
                end
            end
            if (bus1.ready0) begin
                if (rq1.size() == 0) unexpected("rdy1_p0_extra");
                else begin
                    r = rq1.pop_front();
                    chk("rdy1_p0_port", 64'(0), 64'(r.port));
                    chk("rdy1_p0_cyc", 64'(cyc), 64'(r.cyc));
                    chk("rdy1_p0_rdata", 64'(bus1.rdata0), 64'(r.rdata));
                end
            end
            if (bus1.ready1) begin
                if (rq1.size() == 0) unexpected("rdy1_p1_extra");
                else begin
                    r = rq1.pop_front();
                    chk("rdy1_p1_port", 64'(1), 64'(r.port));
                    chk("rdy1_p1_cyc", 64'(cyc), 64'(r.cyc));
                    chk("rdy1_p1_rdata", 64'(bus1.rdata1), 64'(r.rdata));
                end
            end
        end
    end

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (rst3 === 1'b0) begin
            if (!bus3.CEN) begin
                if (cq3.size() == 0) unexpected("cmd3_extra");
                else begin
                    c = cq3.pop_front();
                    chk("cmd3_cyc", 64'(cyc), 64'(c.cyc));
                    chk("cmd3_WEN", 64'(bus3.WEN), 64'(c.wen));
                    chk("cmd3_A", 64'(bus3.A), 64'(c.a));
                    chk("cmd3_D", 64'(bus3.D), 64'(c.d));
                end
            end
            if (bus3.ready0) begin
                if (rq3.size() == 0) unexpected("rdy3_p0_extra");
                else begin
                    r = rq3.pop_front();
                    chk("rdy3_p0_port", 64'(0), 64'(r.port));
                    chk("rdy3_p0_cyc", 64'(cyc), 64'(r.cyc));
                    chk("rdy3_p0_rdata", 64'(bus3.rdata0), 64'(r.rdata));
                end
            end
            if (bus3.ready1) begin
                if (rq3.size() == 0) unexpected("rdy3_p1_extra");
                else begin
                    r = rq3.pop_front();
                    chk("rdy3_p1_port", 64'(1), 64'(r.port));
                    chk("rdy3_p1_cyc", 64'(cyc), 64'(r.cyc));
                    chk("rdy3_p1_rdata", 64'(bus3.rdata1), 64'(r.rdata));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dut, input int port, input logic rq, input logic we,
                         input logic [6:0] a, input logic [31:0] wd);
        if (dut == 1) begin
            if (port == 0) begin bus1.req0 = rq; bus1.we0 = we; bus1.addr0 = a; bus1.wdata0 = wd; end
            else           begin bus1.req1 = rq; bus1.we1 = we; bus1.addr1 = a; bus1.wdata1 = wd; end
        end else begin
            if (port == 0) begin bus3.req0 = rq; bus3.we0 = we; bus3.addr0 = a; bus3.wdata0 = wd; end
            else           begin bus3.req1 = rq; bus3.we1 = we; bus3.addr1 = a; bus3.wdata1 = wd; end
        end
    endtask

    task automatic exp_cmd(input int dut, input logic we, input logic [6:0] a, input logic [31:0] d, input int t);
        cmd_t c;
        c.wen = ~we; c.a = a; c.d = d; c.cyc = t;
        if (dut == 1) cq1.push_back(c); else cq3.push_back(c);
    endtask

    task automatic exp_rsp(input int dut, input int port, input logic [31:0] rd, input int t);
        rsp_t r;
        r.port = port; r.rdata = rd; r.cyc = t;
        if (dut == 1) rq1.push_back(r); else rq3.push_back(r);
    endtask

    // Starts in an IDLE cycle; CMD follows next cycle, ready MEM_LAT+1 cycles after the request cycle.
    task automatic single(input int dut, input int port, input logic we, input logic [6:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        int lat;
        lat = (dut == 1) ? 1 : 3;
        exp_cmd(dut, we, a, wd, cyc + 1);
        exp_rsp(dut, port, exp_rd, cyc + lat + 1);
        drive(dut, port, 1'b1, we, a, wd);
        tick(lat + 1);
        drive(dut, port, 1'b0, 1'b0, 7'h00, 32'h0);
        tick(1);
    endtask

    task automatic chk_reset(input int dut);
        if (dut == 1) begin
            chk("rst1_CEN", 64'(bus1.CEN), 64'(1)); chk("rst1_WEN", 64'(bus1.WEN), 64'(1));
            chk("rst1_A", 64'(bus1.A), 64'(0));     chk("rst1_D", 64'(bus1.D), 64'(0));
            chk("rst1_OEN", 64'(bus1.OEN), 64'(0));
            chk("rst1_ready", 64'({bus1.ready1, bus1.ready0}), 64'(0));
            chk("rst1_rdata0", 64'(bus1.rdata0), 64'(0)); chk("rst1_rdata1", 64'(bus1.rdata1), 64'(0));
        end else begin
            chk("rst3_CEN", 64'(bus3.CEN), 64'(1)); chk("rst3_WEN", 64'(bus3.WEN), 64'(1));
            chk("rst3_A", 64'(bus3.A), 64'(0));     chk("rst3_D", 64'(bus3.D), 64'(0));
            chk("rst3_ready", 64'({bus3.ready1, bus3.ready0}), 64'(0));
            chk("rst3_rdata0", 64'(bus3.rdata0), 64'(0)); chk("rst3_rdata1", 64'(bus3.rdata1), 64'(0));
        end
    endtask

    initial begin
        int n;
        rst1 = 1'b1;
        rst3 = 1'b1;
        for (int d = 1; d <= 3; d += 2) begin
            drive(d, 0, 1'b0, 1'b0, 7'h00, 32'h0);
            drive(d, 1, 1'b0, 1'b0, 7'h00, 32'h0);
        end
        tick(3);
        chk_reset(1);
        chk_reset(3);
        rst1 = 1'b0;
        rst3 = 1'b0;
        tick(2);

        // MEM_LAT=1: single read, write, read-back, boundary address on port 0
        single(1, 1, 1'b0, 7'h05, 32'h0, 32'hDEAD_BEEF);
        single(1, 1, 1'b1, 7'h10, 32'h1234_5678, 32'hDEAD_BEEF);
        single(1, 1, 1'b0, 7'h10, 32'h0, 32'h1234_5678);
        single(1, 0, 1'b0, 7'h05, 32'h0, 32'hDEAD_BEEF);
        single(1, 0, 1'b1, 7'h7F, 32'hA5A5_5A5A, 32'hDEAD_BEEF);
        single(1, 0, 1'b0, 7'h7F, 32'h0, 32'hA5A5_5A5A);

        // Contention: port 0 last won, so port 1 goes first here; grants 1,0,1,0, three cycles apart
        n = cyc;
        drive(1, 0, 1'b1, 1'b0, 7'h05, 32'h0);
        drive(1, 1, 1'b1, 1'b0, 7'h10, 32'h0);
        exp_cmd(1, 1'b0, 7'h10, 32'h0, n + 1);  exp_rsp(1, 1, 32'h1234_5678, n + 2);
        exp_cmd(1, 1'b0, 7'h05, 32'h0, n + 4);  exp_rsp(1, 0, 32'hDEAD_BEEF, n + 5);
        exp_cmd(1, 1'b0, 7'h10, 32'h0, n + 7);  exp_rsp(1, 1, 32'h1234_5678, n + 8);
        exp_cmd(1, 1'b0, 7'h05, 32'h0, n + 10); exp_rsp(1, 0, 32'hDEAD_BEEF, n + 11);
        tick(11);
        drive(1, 0, 1'b0, 1'b0, 7'h00, 32'h0);
        drive(1, 1, 1'b0, 1'b0, 7'h00, 32'h0);
        tick(1);
`ifdef MEM_PORT_ARB_STATS_EN
        chk("stat_conflict", 64'(bus1.conflict_cnt), 64'(4));
        chk("stat_gnt0", 64'(bus1.gnt_cnt0), 64'(5));
        chk("stat_gnt1", 64'(bus1.gnt_cnt1), 64'(5));
`endif

        // Request dropped during CMD still completes with one ready pulse
        n = cyc;
        exp_cmd(1, 1'b0, 7'h05, 32'h0, n + 1);
        exp_rsp(1, 0, 32'hDEAD_BEEF, n + 2);
        drive(1, 0, 1'b1, 1'b0, 7'h05, 32'h0);
        tick(1);
        drive(1, 0, 1'b0, 1'b0, 7'h00, 32'h0);
        tick(5);

        // MEM_LAT=3: ready four cycles after the request cycle, single CEN-low cycle
        single(3, 0, 1'b0, 7'h22, 32'h0, 32'hCAFE_F00D);

        // Reset during WAIT: access lost, outputs clear at once, pointer back to port 0
        n = cyc;
        exp_cmd(3, 1'b0, 7'h23, 32'h0, n + 1);
        drive(3, 0, 1'b1, 1'b0, 7'h23, 32'h0);
        tick(2);
        #3;
        drive(3, 0, 1'b0, 1'b0, 7'h00, 32'h0);
        rst3 = 1'b1;
        #1;
        chk("midrst_CEN", 64'(bus3.CEN), 64'(1));
        chk("midrst_ready0", 64'(bus3.ready0), 64'(0));
        chk("midrst_rdata0", 64'(bus3.rdata0), 64'(0));
        tick(1);
        rst3 = 1'b0;
        tick(1);

        n = cyc;
        drive(3, 0, 1'b1, 1'b0, 7'h22, 32'h0);
        drive(3, 1, 1'b1, 1'b0, 7'h24, 32'h0);
        exp_cmd(3, 1'b0, 7'h22, 32'h0, n + 1); exp_rsp(3, 0, 32'hCAFE_F00D, n + 4);
        exp_cmd(3, 1'b0, 7'h24, 32'h0, n + 6); exp_rsp(3, 1, 32'h5555_AAAA, n + 9);
        tick(4);
        drive(3, 0, 1'b0, 1'b0, 7'h00, 32'h0);
        tick(5);
        drive(3, 1, 1'b0, 1'b0, 7'h00, 32'h0);
        tick(4);

        chk("drain_rsp1", 64'(rq1.size()), 64'(0));
        chk("drain_cmd1", 64'(cq1.size()), 64'(0));
        chk("drain_rsp3", 64'(rq3.size()), 64'(0));
        chk("drain_cmd3", 64'(cq3.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
